calc_stack: RTL and testbench
=============================

// Module: calc_stack
// PURPOSE
//  Parametrised operand stack for the calculator datapath. Generalised in width and depth.
//  Adds a single op-code interface, push-with-value, a binary-op reduce, swap and clear.
//  Adds separate sticky overflow/underflow flags. Sits between the key decoder/ALU and the display.
//  The stack is never empty: it always holds 1..DEPTH entries. The top entry is the current
//  entry line.
// PARAMETERS
//  WIDTH  32  data bits per entry
//  DEPTH  64  max entries; power of two, >= 2
//  CW     $clog2(DEPTH)+1 (localparam)  width of count
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  op         in   3      operation code, sampled every rising edge
//  value      in   WIDTH  operand for WRITE / PUSH_VAL / REDUCE
//  top        out  WIDTH  current top entry
//  next       out  WIDTH  entry below top; 0 when count==1
//  count      out  CW     number of entries, 1..DEPTH
//  full       out  1      count==DEPTH
//  overflow   out  1      sticky: push attempted while full
//  underflow  out  1      sticky: drop attempted with count==1
//  error      out  1      overflow | underflow
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset: count=1, entry0=0, top=0, next=0, full=0, overflow=0, underflow=0.
//  - Reset has priority over any op in the same cycle.
//  - Reset mid-sequence discards all state; other entries are don't-care and never observable.
//  - top, next, count and full are combinational views of registered state.
//    They reflect an op on the edge after it is sampled (latency 1 clock, no handshake).
//    One op per cycle; every op is accepted.
//  - Op codes:
//    000 NOP       no change
//    001 PUSH      count+1; new top=0
//    010 POP       count-1; old top discarded
//    011 WRITE     top<=value; count unchanged
//    100 PUSH_VAL  count+1; new top=value
//    101 REDUCE    count-1; new top (old next)<=value. ALU result replaces two operands.
//    110 SWAP      top and next exchange; count unchanged
//    111 CLEAR     count=1, top=0; overflow and underflow cleared
//  - Boundaries:
//    * PUSH/PUSH_VAL when full: stack unchanged, overflow<=1.
//    * POP/REDUCE/SWAP when count==1: stack unchanged, underflow<=1.
//    * Flags are sticky until reset or CLEAR. Ops still execute normally while flags are set.
//    * A push that lands on a previously used slot must present 0 (PUSH) or value (PUSH_VAL).
//      Stale data is never visible.
//    * count never wraps; it is saturated by the error rules above.
//  - Storage: DEPTH x WIDTH register array (or inferred RAM with combinational read).
//    One write per cycle, plus a second write for SWAP.
// CONFIGURATION
//  CALC_STACK_PEEK_EN defined:
//    - adds peek_idx (in, CW-1 bits) and peek_data (out, WIDTH).
//    - peek_data is the entry at depth peek_idx below top (0 = top), combinational.
//    - peek_data is 0 when peek_idx >= count. Used by the multi-line display.
//  CALC_STACK_PEEK_EN undefined: the ports are absent; no extra read logic.
// TESTING
//  1 Reset -> count=1, top=0, next=0, error=0; hold reset while op=PUSH_VAL -> still count=1.
//  2 PUSH_VAL 5, PUSH_VAL 7, REDUCE value=12 -> count=2, top=12, next=0; SWAP -> top=0, next=12.
//  3 WRITE 9, PUSH, POP -> top=9; PUSH after a POP reuses the slot -> new top=0, not stale data.
//  4 DEPTH-1 pushes -> full=1, count=DEPTH; one more PUSH_VAL 3 -> overflow=1, count and top unchanged.
//  5 From count=1: POP -> underflow=1, top unchanged; PUSH_VAL 4 -> count=2, underflow stays 1;
//    CLEAR -> count=1, top=0, error=0.
//  6 (PEEK_EN) PUSH_VAL 1,2,3 -> peek_idx 0/1/2/3 -> 3/2/1/0; peek_idx 5 -> 0.

Source files
------------

// File: rtl/calc_stack.sv
// ============================================================================
//  Module   : calc_stack
//  Purpose  : Never-empty operand stack (1..DEPTH entries) for the calculator
//             datapath, with op-code control and sticky overflow/underflow.
//             Optional peek port enabled by defining CALC_STACK_PEEK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_value,
`ifdef CALC_STACK_PEEK_EN
    input  logic [CW-2:0]    i_peek_idx,
    output logic [WIDTH-1:0] o_peek_data,
`endif
    output logic [WIDTH-1:0] o_top,
    output logic [WIDTH-1:0] o_next,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_error
);

    localparam int AW = CW - 1;

    localparam logic [2:0] c_op_nop      = 3'b000;
    localparam logic [2:0] c_op_push     = 3'b001;
    localparam logic [2:0] c_op_pop      = 3'b010;
    localparam logic [2:0] c_op_write    = 3'b011;
    localparam logic [2:0] c_op_push_val = 3'b100;
    localparam logic [2:0] c_op_reduce   = 3'b101;
    localparam logic [2:0] c_op_swap     = 3'b110;
    localparam logic [2:0] c_op_clear    = 3'b111;

    localparam logic [CW-1:0] c_count_one  = CW'(1);
    localparam logic [CW-1:0] c_count_full = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_next_idx;
    logic [AW-1:0]    w_push_idx;
    logic             w_single;
    logic             w_full;
    logic [WIDTH-1:0] w_top_data;
    logic [WIDTH-1:0] w_next_data;

    logic             w_we_a;
    logic [AW-1:0]    w_addr_a;
    logic [WIDTH-1:0] w_data_a;
    logic             w_we_b;
    logic [AW-1:0]    w_addr_b;
    logic [WIDTH-1:0] w_data_b;
    logic [CW-1:0]    w_count_nxt;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic             w_clear_flags;

    // count == DEPTH has all-zero low bits, so modular index arithmetic on
    // the low AW bits still lands on DEPTH-1 for the top slot.
    assign w_top_idx   = r_count[AW-1:0] - AW'(1);
    assign w_next_idx  = r_count[AW-1:0] - AW'(2);
    assign w_push_idx  = r_count[AW-1:0];
    assign w_single    = (r_count == c_count_one);
    assign w_full      = (r_count == c_count_full);
    assign w_top_data  = r_mem[w_top_idx];
    assign w_next_data = w_single ? '0 : r_mem[w_next_idx];

    always_comb begin
        w_we_a        = 1'b0;
        w_addr_a      = w_top_idx;
        w_data_a      = '0;
        w_we_b        = 1'b0;
        w_addr_b      = w_next_idx;
        w_data_b      = '0;
        w_count_nxt   = r_count;
        w_set_ovf     = 1'b0;
        w_set_udf     = 1'b0;
        w_clear_flags = 1'b0;
        case (i_op)
            c_op_nop: ;
            c_op_push, c_op_push_val: begin
                if (w_full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    // Always write the new slot so stale data never resurfaces.
                    w_we_a      = 1'b1;
                    w_addr_a    = w_push_idx;
                    w_data_a    = (i_op == c_op_push_val) ? i_value : '0;
                    w_count_nxt = r_count + c_count_one;
                end
            end
            c_op_pop: begin
                if (w_single) w_set_udf = 1'b1;
                else          w_count_nxt = r_count - c_count_one;
            end
            c_op_write: begin
                w_we_a   = 1'b1;
                w_data_a = i_value;
            end
            c_op_reduce: begin
                if (w_single) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_we_a      = 1'b1;
                    w_addr_a    = w_next_idx;
                    w_data_a    = i_value;
                    w_count_nxt = r_count - c_count_one;
                end
            end
            c_op_swap: begin
                if (w_single) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_we_a   = 1'b1;
                    w_data_a = w_next_data;
                    w_we_b   = 1'b1;
                    w_data_b = w_top_data;
                end
            end
            c_op_clear: begin
                w_we_a        = 1'b1;
                w_addr_a      = '0;
                w_count_nxt   = c_count_one;
                w_clear_flags = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count     <= c_count_one;
            r_mem[0]    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_we_a) r_mem[w_addr_a] <= w_data_a;
            if (w_we_b) r_mem[w_addr_b] <= w_data_b;
            if (w_clear_flags) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_overflow  <= r_overflow  | w_set_ovf;
                r_underflow <= r_underflow | w_set_udf;
            end
        end
    end

`ifdef CALC_STACK_PEEK_EN
    logic [AW-1:0] w_peek_addr;
    assign w_peek_addr = w_top_idx - i_peek_idx;
    assign o_peek_data = ({1'b0, i_peek_idx} < r_count) ? r_mem[w_peek_addr] : '0;
`endif

    assign o_top       = w_top_data;
    assign o_next      = w_next_data;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
    assign o_error     = r_overflow | r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_calc_stack.sv
// ============================================================================
//  Module   : tb_calc_stack
//  Purpose  : Self-checking bench for calc_stack against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calc_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       op;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] top, nxt;
    logic [CW-1:0]    count;
    logic             full, ovf, udf, err;
`ifdef CALC_STACK_PEEK_EN
    logic [CW-2:0]    peek_idx;
    logic [WIDTH-1:0] peek_data;
`endif

    always #5 clk = ~clk;

    calc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_op        (op),
        .i_value     (value),
`ifdef CALC_STACK_PEEK_EN
        .i_peek_idx  (peek_idx),
        .o_peek_data (peek_data),
`endif
        .o_top       (top),
        .o_next      (nxt),
        .o_count     (count),
        .o_full      (full),
        .o_overflow  (ovf),
        .o_underflow (udf),
        .o_error     (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stack as a queue, index 0 = bottom.
    logic [WIDTH-1:0] stk[$];
    bit               m_ovf, m_udf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        stk.push_back('0);
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic model_apply(input logic [2:0] o, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        case (o)
            3'd1, 3'd4: begin
                if (stk.size() == DEPTH) m_ovf = 1;
                else stk.push_back(o == 3'd4 ? v : '0);
            end
            3'd2: if (stk.size() == 1) m_udf = 1; else void'(stk.pop_back());
            3'd3: stk[stk.size()-1] = v;
            3'd5: begin
                if (stk.size() == 1) m_udf = 1;
                else begin
                    void'(stk.pop_back());
                    stk[stk.size()-1] = v;
                end
            end
            3'd6: begin
                if (stk.size() == 1) m_udf = 1;
                else begin
                    t = stk[stk.size()-1];
                    stk[stk.size()-1] = stk[stk.size()-2];
                    stk[stk.size()-2] = t;
                end
            end
            3'd7: begin
                stk.delete();
                stk.push_back('0);
                m_ovf = 0;
                m_udf = 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_state();
        int n;
        n = stk.size();
        chk("top",       top,   stk[n-1]);
        chk("next",      nxt,   (n > 1) ? stk[n-2] : '0);
        chk("count",     count, n);
        chk("full",      full,  n == DEPTH);
        chk("overflow",  ovf,   m_ovf);
        chk("underflow", udf,   m_udf);
        chk("error",     err,   m_ovf | m_udf);
`ifdef CALC_STACK_PEEK_EN
        chk("peek", peek_data, (int'(peek_idx) < n) ? stk[n-1-int'(peek_idx)] : '0);
`endif
    endtask

    task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] v);
        op    = o;
        value = v;
`ifdef CALC_STACK_PEEK_EN
        peek_idx = CW'($urandom_range(0, DEPTH - 1));
`endif
        @(posedge clk);
        model_apply(o, v);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        op    = 3'd4;
        value = $urandom;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_state();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        op    = 3'd0;
        value = '0;
`ifdef CALC_STACK_PEEK_EN
        peek_idx = '0;
`endif
        model_reset();

        // 1: reset held while PUSH_VAL is presented
        do_reset();
        chk("rst_count", count, 1);
        chk("rst_top",   top,   0);

        // 2: push/push/reduce then swap
        step(3'd4, 5);
        step(3'd4, 7);
        step(3'd5, 12);
        chk("reduce_top",   top,   12);
        chk("reduce_count", count, 2);
        step(3'd6, 0);
        chk("swap_top",  top, 0);
        chk("swap_next", nxt, 12);

        // 3: write / push / pop, then slot reuse after pop
        step(3'd3, 9);
        step(3'd1, 0);
        step(3'd2, 0);
        chk("pop_top", top, 9);
        step(3'd4, 32'h55);
        step(3'd2, 0);
        step(3'd1, 0);
        chk("reuse_top", top, 0);

        // 4: fill to full, then overflow
        step(3'd7, 0);
        for (int i = 0; i < DEPTH - 1; i++) step(3'd4, $urandom);
        chk("full_flag",  full,  1);
        chk("full_count", count, DEPTH);
        step(3'd4, 3);
        chk("ovf_flag",  ovf,   1);
        chk("ovf_count", count, DEPTH);

        // 5: underflow from count==1, sticky across push, cleared by CLEAR
        step(3'd7, 0);
        step(3'd2, 0);
        chk("udf_flag", udf, 1);
        step(3'd4, 4);
        chk("udf_sticky", udf, 1);
        chk("udf_count",  count, 2);
        step(3'd7, 0);
        chk("clr_err",   err,   0);
        chk("clr_count", count, 1);

`ifdef CALC_STACK_PEEK_EN
        // 6: peek across the stack and past its end
        step(3'd4, 1);
        step(3'd4, 2);
        step(3'd4, 3);
        op = 3'd0;
        for (int i = 0; i < 6; i++) begin
            peek_idx = CW'(i);
            #1;
            chk("peek_dir", peek_data, (i < 4) ? (3 - i) : 0);
        end
        step(3'd7, 0);
`endif

        // Randomised run, push-biased so full/overflow are reached
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [2:0] o;
            r = $urandom_range(0, 99);
            if (r < 30)      o = 3'd4;
            else if (r < 40) o = 3'd1;
            else if (r < 98) o = 3'($urandom_range(0, 6));
            else             o = 3'd7;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(o, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
